int_gateway_array: RTL and testbench

- Per-source interrupt gateway array. Sits directly downstream of the interrupt crossbar.
- Takes the crossbar's flat interrupt vector, synchronises each line, and holds each source's request in a gateway FSM.
- Presents a pending vector and the highest-priority pending ID to the PLIC core.
- Enforces the one-outstanding-request claim/complete protocol per source.

---
 rtl/int_pkg.sv | 17 +
 rtl/int_gateway.sv | 85 ++++++++
 rtl/int_gateway_array.sv | 61 ++++++
 tb/tb_int_gateway_array.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared gateway state, ID constants and ID width helper
package int_pkg;

   typedef enum logic [1:0] {
      GW_IDLE,
      GW_PENDING,
      GW_CLAIMED
   } gw_state_t;

   localparam int INT_NO_ID = 0;

   // IDs run 1..n with 0 reserved, so n+1 codes are needed
   function automatic int id_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/int_gateway.sv
// rtl/int_gateway.sv - single-source synchroniser and claim/complete gateway FSM
// Optional edge-triggered request flag enabled by INT_GW_EDGE_EN.
module int_gateway
   import int_pkg::*;
#(
   parameter int SYNC_STAGES = 2
`ifdef INT_GW_EDGE_EN
   ,
   parameter bit EDGE        = 1'b0
`endif
) (
   input  logic clock,
   input  logic reset,
   input  logic line,
   input  logic claim_hit,
   input  logic complete_hit,
   output logic pending,
   output logic claimed
);

   logic      req;
   logic      trig;
   gw_state_t state_q;
   gw_state_t state_d;

   if (SYNC_STAGES == 0) begin : g_nosync
      assign req = line;
   end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            sync_q <= '0;
         end else begin
            sync_q[0] <= line;
            for (int s = 1; s < SYNC_STAGES; s++) begin
               sync_q[s] <= sync_q[s-1];
            end
         end
      end
      assign req = sync_q[SYNC_STAGES-1];
   end

`ifdef INT_GW_EDGE_EN
   if (EDGE) begin : g_edge
      logic req_q;
      logic flag_q;
      // One-deep sticky flag: leaving IDLE consumes it, further edges collapse into it
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            req_q  <= 1'b0;
            flag_q <= 1'b0;
         end else begin
            req_q  <= req;
            flag_q <= (flag_q && (state_q != GW_IDLE)) || (req && !req_q);
         end
      end
      assign trig = flag_q;
   end else begin : g_level
      assign trig = req;
   end
`else
   assign trig = req;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= GW_IDLE;
      else       state_q <= state_d;
   end

   // Strobes only act in the state they apply to, so a same-cycle claim and
   // complete of one source can never both fire
   always_comb begin
      state_d = state_q;
      case (state_q)
         GW_IDLE:    if (trig)         state_d = GW_PENDING;
         GW_PENDING: if (claim_hit)    state_d = GW_CLAIMED;
         GW_CLAIMED: if (complete_hit) state_d = GW_IDLE;
         default:                      state_d = GW_IDLE;
      endcase
   end

   assign pending = (state_q == GW_PENDING);
   assign claimed = (state_q == GW_CLAIMED);

endmodule

// File: rtl/int_gateway_array.sv
// rtl/int_gateway_array.sv - per-source interrupt gateways with lowest-ID-first pending encoder
// Optional edge-triggered sources via INT_GW_EDGE_EN (adds EDGE_MASK).
module int_gateway_array
   import int_pkg::*;
#(
   parameter int NUM_SRC     = 5,
   parameter int ID_W        = id_width(NUM_SRC),
   parameter int SYNC_STAGES = 2
`ifdef INT_GW_EDGE_EN
   ,
   parameter logic [NUM_SRC-1:0] EDGE_MASK = '0
`endif
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] int_in,
   output logic [NUM_SRC-1:0] pending,
   output logic               top_valid,
   output logic [ID_W-1:0]    top_id,
   input  logic               claim_valid,
   input  logic [ID_W-1:0]    claim_id,
   input  logic               complete_valid,
   input  logic [ID_W-1:0]    complete_id,
   output logic [NUM_SRC-1:0] claimed
);

   logic [NUM_SRC-1:0] claim_hit;
   logic [NUM_SRC-1:0] complete_hit;

   // ID 0 and IDs above NUM_SRC match no gateway and are dropped here
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_gw
      assign claim_hit[i]    = claim_valid    && (claim_id    == ID_W'(i + 1));
      assign complete_hit[i] = complete_valid && (complete_id == ID_W'(i + 1));

      int_gateway #(
         .SYNC_STAGES (SYNC_STAGES)
`ifdef INT_GW_EDGE_EN
         ,
         .EDGE        (EDGE_MASK[i])
`endif
      ) u_gw (
         .clock        (clock),
         .reset        (reset),
         .line         (int_in[i]),
         .claim_hit    (claim_hit[i]),
         .complete_hit (complete_hit[i]),
         .pending      (pending[i]),
         .claimed      (claimed[i])
      );
   end

   always_comb begin
      top_id = ID_W'(INT_NO_ID);
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pending[i]) top_id = ID_W'(i + 1);
      end
   end

   assign top_valid = |pending;

endmodule

// File: tb/tb_int_gateway_array.sv
// tb/tb_int_gateway_array.sv - self-checking bench for int_gateway_array against a behavioural model
module tb_int_gateway_array;

   localparam int NUM_SRC     = 5;
   localparam int ID_W        = 3;
   localparam int SYNC_STAGES = 2;
`ifdef INT_GW_EDGE_EN
   localparam logic [NUM_SRC-1:0] EDGE_MASK = 5'b00001;
`endif

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic [NUM_SRC-1:0] int_in = '0;
   logic [NUM_SRC-1:0] pending;
   logic               top_valid;
   logic [ID_W-1:0]    top_id;
   logic               claim_valid = 1'b0;
   logic [ID_W-1:0]    claim_id = '0;
   logic               complete_valid = 1'b0;
   logic [ID_W-1:0]    complete_id = '0;
   logic [NUM_SRC-1:0] claimed;

   int n_checks = 0;
   int n_errors = 0;

   // model: 0 idle, 1 pending, 2 claimed; hist holds int_in seen at the last SYNC_STAGES edges
   int                 mst[NUM_SRC];
   logic [NUM_SRC-1:0] hist[$];
   logic [NUM_SRC-1:0] m_prev;
   logic [NUM_SRC-1:0] m_flag;

   always #5 clock = ~clock;

   int_gateway_array #(
      .NUM_SRC     (NUM_SRC),
      .ID_W        (ID_W),
      .SYNC_STAGES (SYNC_STAGES)
`ifdef INT_GW_EDGE_EN
      ,
      .EDGE_MASK   (EDGE_MASK)
`endif
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .int_in         (int_in),
      .pending        (pending),
      .top_valid      (top_valid),
      .top_id         (top_id),
      .claim_valid    (claim_valid),
      .claim_id       (claim_id),
      .complete_valid (complete_valid),
      .complete_id    (complete_id),
      .claimed        (claimed)
   );

   task automatic model_reset();
      for (int i = 0; i < NUM_SRC; i++) mst[i] = 0;
      hist.delete();
      for (int s = 0; s < SYNC_STAGES; s++) hist.push_back('0);
      m_prev = '0;
      m_flag = '0;
   endtask

   task automatic step();
      logic [NUM_SRC-1:0] req;
      int nxt[NUM_SRC];
      hist.push_back(int_in);
      req = hist.pop_front();
      for (int i = 0; i < NUM_SRC; i++) begin
         logic trig;
         trig = req[i];
`ifdef INT_GW_EDGE_EN
         if (EDGE_MASK[i]) begin
            trig      = m_flag[i];
            m_flag[i] = (m_flag[i] && mst[i] != 0) || (req[i] && !m_prev[i]);
         end
`endif
         nxt[i] = mst[i];
         if (mst[i] == 0 && trig) nxt[i] = 1;
         if (mst[i] == 1 && claim_valid && int'(claim_id) == i + 1) nxt[i] = 2;
         if (mst[i] == 2 && complete_valid && int'(complete_id) == i + 1) nxt[i] = 0;
      end
      m_prev = req;
      @(posedge clock);
      #1;
      for (int i = 0; i < NUM_SRC; i++) mst[i] = nxt[i];
   endtask

   task automatic check(input string tag);
      logic [NUM_SRC-1:0] ep;
      logic [NUM_SRC-1:0] ec;
      logic [ID_W-1:0]    eid;
      ep  = '0;
      ec  = '0;
      eid = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ep[i] = (mst[i] == 1);
         ec[i] = (mst[i] == 2);
      end
      for (int i = NUM_SRC - 1; i >= 0; i--) if (ep[i]) eid = ID_W'(i + 1);
      n_checks += 4;
      assert (pending === ep) else begin
         n_errors++; $error("FAIL %s pending got %b exp %b", tag, pending, ep);
      end
      assert (claimed === ec) else begin
         n_errors++; $error("FAIL %s claimed got %b exp %b", tag, claimed, ec);
      end
      assert (top_valid === (ep != '0)) else begin
         n_errors++; $error("FAIL %s top_valid got %b exp %b", tag, top_valid, ep != '0);
      end
      assert (top_id === eid) else begin
         n_errors++; $error("FAIL %s top_id got %0d exp %0d", tag, top_id, eid);
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++; $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic strobe(input logic cv, input int cid, input logic pv, input int pid);
      claim_valid    = cv;
      claim_id       = ID_W'(cid);
      complete_valid = pv;
      complete_id    = ID_W'(pid);
      step();
      claim_valid    = 1'b0;
      complete_valid = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clock);
      #3;
      chk("rst_pending", 8'(pending), 8'h00);
      chk("rst_claimed", 8'(claimed), 8'h00);
      chk("rst_top_valid", 8'(top_valid), 8'h00);
      chk("rst_top_id", 8'(top_id), 8'h00);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // latency: source 3 pends two edges after the first sampling edge
      int_in = 5'b00100;
      step(); check("lat1"); chk("lat1_pending", 8'(pending), 8'h00);
      step(); check("lat2"); chk("lat2_pending", 8'(pending), 8'h00);
      step(); check("lat3");
      chk("lat3_pending", 8'(pending), 8'h04);
      chk("lat3_top_id", 8'(top_id), 8'h03);

      // retire source 3, then pend 2 and 4
      int_in = '0;
      strobe(1'b1, 3, 1'b0, 0); check("clr3_claim");
      strobe(1'b0, 0, 1'b1, 3); check("clr3_complete");
      int_in = 5'b01010;
      repeat (3) step();
      check("p24");
      chk("p24_top_id", 8'(top_id), 8'h02);
      strobe(1'b1, 2, 1'b0, 0); check("claim2");
      chk("claim2_claimed", 8'(claimed), 8'h02);
      chk("claim2_top_id", 8'(top_id), 8'h04);
      strobe(1'b0, 0, 1'b1, 2); check("complete2");
      step(); check("repend2");
      chk("repend2_top_id", 8'(top_id), 8'h02);

      // ignored strobes
      strobe(1'b1, 0, 1'b0, 0); check("claim_id0");
      strobe(1'b1, 7, 1'b0, 0); check("claim_id7");
      strobe(1'b1, 5, 1'b0, 0); check("claim_nonpend5");
      strobe(1'b0, 0, 1'b1, 4); check("complete_pend4");
      chk("ignored_pending", 8'(pending), 8'h0A);
      chk("ignored_claimed", 8'(claimed), 8'h00);

      // dropped lines stay latched; same-cycle claim and complete
      int_in = 5'b00101;
      repeat (3) step();
      check("p1234");
      strobe(1'b1, 3, 1'b0, 0); check("claim3");
      strobe(1'b1, 1, 1'b1, 3); check("claim1_complete3");
`ifndef INT_GW_EDGE_EN
      chk("c1c3_claimed", 8'(claimed), 8'h01);
      chk("c1c3_pending", 8'(pending), 8'h0A);
`endif
      step(); check("repend3");
      strobe(1'b0, 0, 1'b1, 1); check("complete1");
      step(); check("repend1");
      strobe(1'b1, 1, 1'b1, 1); check("claim_complete1_same");
`ifndef INT_GW_EDGE_EN
      chk("same_id_claimed1", 8'(claimed[0]), 8'h01);
`endif

      // asynchronous reset in the middle of a cycle
      strobe(1'b1, 2, 1'b0, 0); check("claim2_again");
      #2 reset = 1'b1;
      #1;
      chk("async_pending", 8'(pending), 8'h00);
      chk("async_claimed", 8'(claimed), 8'h00);
      chk("async_top_valid", 8'(top_valid), 8'h00);
      model_reset();
      #2 reset = 1'b0;
      step(); check("post_rst1");
      step(); check("post_rst2");
      chk("post_rst2_pending", 8'(pending), 8'h00);
      step(); check("post_rst3");
      chk("post_rst3_pend3", 8'(pending[2]), 8'h01);

`ifdef INT_GW_EDGE_EN
      // edge source 1: one pulse pends; two pulses while claimed give exactly one re-pend
      int_in = '0;
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      model_reset();
      repeat (3) step();
      int_in = 5'b00001; step();
      int_in = 5'b00000;
      repeat (4) step();
      check("edge_pend");
      chk("edge_pend1", 8'(pending[0]), 8'h01);
      strobe(1'b1, 1, 1'b0, 0); check("edge_claim");
      int_in = 5'b00001; step(); int_in = '0; step();
      int_in = 5'b00001; step(); int_in = '0; step();
      repeat (3) step();
      strobe(1'b0, 0, 1'b1, 1); check("edge_complete1");
      step(); check("edge_repend");
      chk("edge_repend1", 8'(pending[0]), 8'h01);
      strobe(1'b1, 1, 1'b0, 0); check("edge_claim2");
      strobe(1'b0, 0, 1'b1, 1); check("edge_complete2");
      repeat (3) step();
      check("edge_idle");
      chk("edge_idle_pend", 8'(pending[0]), 8'h00);
      chk("edge_idle_claim", 8'(claimed[0]), 8'h00);
`endif

      // randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         int pick;
         if ($urandom_range(0, 3) == 0) int_in = NUM_SRC'($urandom);
         claim_valid = 1'($urandom_range(0, 1));
         claim_id    = ID_W'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            for (int i = NUM_SRC - 1; i >= 0; i--) if (mst[i] == 1) claim_id = ID_W'(i + 1);
         end
         complete_valid = 1'($urandom_range(0, 1));
         complete_id    = ID_W'($urandom_range(0, 7));
         pick = $urandom_range(0, NUM_SRC - 1);
         if (mst[pick] == 2 && $urandom_range(0, 1) == 1) complete_id = ID_W'(pick + 1);
         step();
         check("random");
         if (c % 150 == 149) begin
            #2 reset = 1'b1;
            #1;
            chk("rand_async_pending", 8'(pending), 8'h00);
            model_reset();
            #2 reset = 1'b0;
         end
      end
      claim_valid    = 1'b0;
      complete_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
